// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants, FSM state type and alignment helper for the MEM-stage LSU.
// Imported by the LSU top and its load-extension sub-module.
package lsu_pkg;

    localparam logic [1:0] WD_DRAM = 2'b01;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    // Unknown funct3 codes are word accesses, so they demand full word alignment.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: isMisaligned = 1'b0;
            F3_H, F3_HU: isMisaligned = offset[0];
            default:     isMisaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage LSU (master) and data memory (slave).
// Signal suffixes are named from the LSU's point of view.
interface mem_stage_lsu_if;

    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;

    modport master (
        output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
        input  dm_ack_i, dm_rdata_i
    );

    modport slave (
        input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
        output dm_ack_i, dm_rdata_i
    );

endinterface

// File: rtl/mem_stage_lsu_load_ext.sv
// Combinational lane select and sign/zero extension of a read word by funct3 and address offset.
// Kept separate so a later forwarding path can reuse the same extension.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (offset_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    ldata_o = {{24{byteSel[7]}}, byteSel};
            F3_H:    ldata_o = {{16{halfSel[15]}}, halfSel};
            F3_BU:   ldata_o = {24'h0, byteSel};
            F3_HU:   ldata_o = {16'h0, halfSel};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one data-memory req/ack transaction per access and stalls the pipeline meanwhile.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             MEM_WdSel_i,
    input  logic                   MEM_DMwe_i,
    input  logic [31:0]            MEM_ALUc_i,
    input  logic [31:0]            MEM_rd2_i,
    input  logic [31:0]            MEM_inst_i,
    mem_stage_lsu_if.master        dm,
    output logic                   lsu_stop_o,
    output logic [31:0]            MEM_ldata_o,
    output logic                   bus_err_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                   misalign_o
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] ldata_q, ldata_d;
    logic        err_q, err_d;

    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        isStore, isLoad, access, misalignHit, ackTake;
    logic [3:0]  beRaw;
    logic [31:0] wdataRaw, loadExt;
    logic        unusedInstBits;

    assign funct3  = MEM_inst_i[14:12];
    assign offset  = MEM_ALUc_i[1:0];
    assign isStore = MEM_DMwe_i;
    assign isLoad  = ~MEM_DMwe_i & (MEM_WdSel_i == WD_DRAM);
    assign access  = isStore | isLoad;
    assign unusedInstBits = ^{MEM_inst_i[31:15], MEM_inst_i[11:0]};

`ifdef MISALIGN_TRAP_EN
    assign misalignHit = isMisaligned(funct3, offset);
`else
    assign misalignHit = 1'b0;
`endif

    // Gating with rst drops the request the instant reset is raised, even mid-transaction.
    assign dm.dm_req_o  = ~rst & (((state_q == IDLE) & access & ~misalignHit) | (state_q == BUSY));
    assign lsu_stop_o   = ~rst & (((state_q == IDLE) & access) | (state_q == BUSY));
    assign dm.dm_we_o   = dm.dm_req_o & isStore;
    assign dm.dm_addr_o = dm.dm_req_o ? {MEM_ALUc_i[31:2], 2'b00} : 32'h0;
    assign dm.dm_be_o   = dm.dm_req_o ? beRaw : 4'h0;
    assign dm.dm_wdata_o = dm.dm_req_o ? wdataRaw : 32'h0;
    assign ackTake      = dm.dm_ack_i & dm.dm_req_o;

    always_comb begin
        beRaw    = 4'hF;
        wdataRaw = 32'h0;
        if (isStore) begin
            case (funct3[1:0])
                2'b00: begin
                    beRaw    = 4'b0001 << offset;
                    wdataRaw = {4{MEM_rd2_i[7:0]}};
                end
                2'b01: begin
                    beRaw    = 4'b0011 << {offset[1], 1'b0};
                    wdataRaw = {2{MEM_rd2_i[15:0]}};
                end
                default: begin
                    beRaw    = 4'hF;
                    wdataRaw = MEM_rd2_i;
                end
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .funct3_i (funct3),
        .offset_i (offset),
        .rdata_i  (dm.dm_rdata_i),
        .ldata_o  (loadExt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldata_d = ldata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misalignHit) begin
                        state_d = DONE;
                    end else if (ackTake) begin
                        state_d = DONE;
                        if (isLoad) ldata_d = loadExt;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(1);
                    end
                end
            end
            BUSY: begin
                if (ackTake) begin
                    state_d = DONE;
                    if (isLoad) ldata_d = loadExt;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (isLoad) ldata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ldata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    // High exactly for the DONE cycle that follows a trapped access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= (state_q == IDLE) & access & misalignHit;
    end

    assign misalign_o = misalign_q;
`endif

    assign MEM_ldata_o = ldata_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu: table of single-access vectors plus hand-written
// back-to-back, timeout and reset-abort sequences.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  MEM_WdSel_i;
    logic        MEM_DMwe_i;
    logic [31:0] MEM_ALUc_i;
    logic [31:0] MEM_rd2_i;
    logic [31:0] MEM_inst_i;
    logic        lsu_stop_o;
    logic [31:0] MEM_ldata_o;
    logic        bus_err_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    mem_stage_lsu_if dmBus ();

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_WdSel_i (MEM_WdSel_i),
        .MEM_DMwe_i  (MEM_DMwe_i),
        .MEM_ALUc_i  (MEM_ALUc_i),
        .MEM_rd2_i   (MEM_rd2_i),
        .MEM_inst_i  (MEM_inst_i),
        .dm          (dmBus),
        .lsu_stop_o  (lsu_stop_o),
        .MEM_ldata_o (MEM_ldata_o),
        .bus_err_o   (bus_err_o)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o  (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        we;
        logic [1:0]  wdSel;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        int          expStop;
        logic [31:0] expLdata;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mkVec(input string name, input logic [2:0] f3, input logic we,
                                   input logic [1:0] wdSel, input logic [31:0] addr,
                                   input logic [31:0] rd2, input logic [31:0] rdata, input int waits,
                                   input logic [31:0] expAddr, input logic [3:0] expBe,
                                   input logic [31:0] expWdata, input int expStop,
                                   input logic [31:0] expLdata);
        vec_t v;
        v.name = name; v.f3 = f3; v.we = we; v.wdSel = wdSel; v.addr = addr; v.rd2 = rd2;
        v.rdata = rdata; v.waits = waits; v.expAddr = expAddr; v.expBe = expBe;
        v.expWdata = expWdata; v.expStop = expStop; v.expLdata = expLdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic setInputs(input logic [2:0] f3, input logic we, input logic [1:0] wdSel,
                             input logic [31:0] addr, input logic [31:0] rd2);
        MEM_inst_i  = {17'h0, f3, 12'h003};
        MEM_DMwe_i  = we;
        MEM_WdSel_i = wdSel;
        MEM_ALUc_i  = addr;
        MEM_rd2_i   = rd2;
    endtask

    task automatic clearInputs();
        MEM_DMwe_i  = 1'b0;
        MEM_WdSel_i = 2'b00;
    endtask

    // Runs one access from IDLE to DONE, acking after v.waits request cycles unless noAck.
    task automatic applyStimulus(input vec_t v, input bit noAck, input logic expErr);
        int  stopCnt;
        int  reqCnt;
        bit  done;
        @(negedge clk);
        setInputs(v.f3, v.we, v.wdSel, v.addr, v.rd2);
        dmBus.dm_ack_i = 1'b0;
        #1;
        checkOutput({v.name, " req"}, 32'(dmBus.dm_req_o), 32'h1);
        checkOutput({v.name, " we"}, 32'(dmBus.dm_we_o), 32'(v.we));
        checkOutput({v.name, " addr"}, dmBus.dm_addr_o, v.expAddr);
        checkOutput({v.name, " be"}, 32'(dmBus.dm_be_o), 32'(v.expBe));
        if (v.we) checkOutput({v.name, " wdata"}, dmBus.dm_wdata_o, v.expWdata);
        stopCnt = 0;
        reqCnt  = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (lsu_stop_o) begin
                stopCnt++;
                dmBus.dm_ack_i   = dmBus.dm_req_o && !noAck && (reqCnt == v.waits);
                dmBus.dm_rdata_i = v.rdata;
                if (dmBus.dm_req_o) reqCnt++;
                @(posedge clk);
                #1 dmBus.dm_ack_i = 1'b0;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({v.name, " completed"}, 32'(done), 32'h1);
        checkOutput({v.name, " stop cycles"}, 32'(stopCnt), 32'(v.expStop));
        checkOutput({v.name, " req in DONE"}, 32'(dmBus.dm_req_o), 32'h0);
        checkOutput({v.name, " ldata"}, MEM_ldata_o, v.expLdata);
        checkOutput({v.name, " bus_err"}, 32'(bus_err_o), 32'(expErr));
        clearInputs();
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mkVec("SW zero-wait", F3_W, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                         32'h100, 4'hF, 32'hDEADBEEF, 1, 32'h0);
        vecs[1]  = mkVec("SB lane3", F3_B, 1'b1, 2'b00, 32'h103, 32'h000000A5, 32'h0, 0,
                         32'h100, 4'b1000, 32'hA5A5A5A5, 1, 32'h0);
        vecs[2]  = mkVec("LB 3 waits", F3_B, 1'b0, WD_DRAM, 32'h102, 32'h0, 32'h00800000, 3,
                         32'h100, 4'hF, 32'h0, 4, 32'hFFFFFF80);
        vecs[3]  = mkVec("LBU 3 waits", F3_BU, 1'b0, WD_DRAM, 32'h102, 32'h0, 32'h00800000, 3,
                         32'h100, 4'hF, 32'h0, 4, 32'h00000080);
        vecs[4]  = mkVec("LHU upper", F3_HU, 1'b0, WD_DRAM, 32'h106, 32'h0, 32'hBEEF1234, 0,
                         32'h104, 4'hF, 32'h0, 1, 32'h0000BEEF);
        vecs[5]  = mkVec("LH upper", F3_H, 1'b0, WD_DRAM, 32'h106, 32'h0, 32'hBEEF1234, 1,
                         32'h104, 4'hF, 32'h0, 2, 32'hFFFFBEEF);
        vecs[6]  = mkVec("LW 2 waits", F3_W, 1'b0, WD_DRAM, 32'h108, 32'h0, 32'h12345678, 2,
                         32'h108, 4'hF, 32'h0, 3, 32'h12345678);
        vecs[7]  = mkVec("SH upper", F3_H, 1'b1, 2'b00, 32'h10A, 32'h1234CAFE, 32'h0, 1,
                         32'h108, 4'b1100, 32'hCAFECAFE, 2, 32'h12345678);
        vecs[8]  = mkVec("LB lane1", F3_B, 1'b0, WD_DRAM, 32'h101, 32'h0, 32'h00007F00, 0,
                         32'h100, 4'hF, 32'h0, 1, 32'h0000007F);
        vecs[9]  = mkVec("funct3 011 as LW", 3'b011, 1'b0, WD_DRAM, 32'h10C, 32'h0, 32'hA5A55A5A, 0,
                         32'h10C, 4'hF, 32'h0, 1, 32'hA5A55A5A);
        vecs[10] = mkVec("store priority", F3_W, 1'b1, WD_DRAM, 32'h110, 32'h01020304, 32'hFFFFFFFF, 2,
                         32'h110, 4'hF, 32'h01020304, 3, 32'hA5A55A5A);

        rst = 1'b1;
        MEM_inst_i = 32'h0;
        MEM_ALUc_i = 32'h0;
        MEM_rd2_i  = 32'h0;
        clearInputs();
        dmBus.dm_ack_i   = 1'b0;
        dmBus.dm_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset req", 32'(dmBus.dm_req_o), 32'h0);
        checkOutput("reset stop", 32'(lsu_stop_o), 32'h0);
        checkOutput("reset ldata", MEM_ldata_o, 32'h0);
        checkOutput("reset bus_err", 32'(bus_err_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle no-access be", 32'(dmBus.dm_be_o), 32'h0);

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

        // Back-to-back: a new access appears during DONE; a stray ack there must be ignored.
        @(negedge clk);
        setInputs(F3_W, 1'b1, 2'b00, 32'h140, 32'h11112222);
        #1 dmBus.dm_ack_i = 1'b1;
        @(posedge clk);
        #1 dmBus.dm_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("b2b DONE stop", 32'(lsu_stop_o), 32'h0);
        setInputs(F3_W, 1'b0, WD_DRAM, 32'h144, 32'h0);
        #1;
        checkOutput("b2b DONE req", 32'(dmBus.dm_req_o), 32'h0);
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 32'hFFFFFFFF;
        @(posedge clk);
        #1 dmBus.dm_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("b2b load req", 32'(dmBus.dm_req_o), 32'h1);
        checkOutput("b2b load addr", dmBus.dm_addr_o, 32'h144);
        checkOutput("b2b stray ack ignored", MEM_ldata_o, 32'hA5A55A5A);
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 32'h0BADF00D;
        @(posedge clk);
        #1 dmBus.dm_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("b2b load stop", 32'(lsu_stop_o), 32'h0);
        checkOutput("b2b load ldata", MEM_ldata_o, 32'h0BADF00D);
        clearInputs();
        @(posedge clk);

`ifndef MISALIGN_TRAP_EN
        applyStimulus(mkVec("LH forced align", F3_H, 1'b0, WD_DRAM, 32'h107, 32'h0, 32'hBEEF1234, 0,
                            32'h104, 4'hF, 32'h0, 1, 32'hFFFFBEEF), 1'b0, 1'b0);
        applyStimulus(mkVec("SW forced align", F3_W, 1'b1, 2'b00, 32'h113, 32'hCAFEF00D, 32'h0, 0,
                            32'h110, 4'hF, 32'hCAFEF00D, 1, 32'hFFFFBEEF), 1'b0, 1'b0);
`else
        @(negedge clk);
        setInputs(F3_W, 1'b0, WD_DRAM, 32'h102, 32'h0);
        #1;
        checkOutput("misalign no req", 32'(dmBus.dm_req_o), 32'h0);
        checkOutput("misalign stop", 32'(lsu_stop_o), 32'h1);
        @(negedge clk);
        checkOutput("misalign flag", 32'(misalign_o), 32'h1);
        checkOutput("misalign DONE stop", 32'(lsu_stop_o), 32'h0);
        checkOutput("misalign ldata kept", MEM_ldata_o, 32'h0BADF00D);
        clearInputs();
        @(negedge clk);
        checkOutput("misalign flag clears", 32'(misalign_o), 32'h0);
`endif

        applyStimulus(mkVec("LW timeout", F3_W, 1'b0, WD_DRAM, 32'h120, 32'h0, 32'h0, 0,
                            32'h120, 4'hF, 32'h0, 17, 32'h0), 1'b1, 1'b1);

        // Reset raised during BUSY abandons the request; a later ack must not matter.
        @(negedge clk);
        setInputs(F3_W, 1'b0, WD_DRAM, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset BUSY req", 32'(dmBus.dm_req_o), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset req", 32'(dmBus.dm_req_o), 32'h0);
        checkOutput("mid reset stop", 32'(lsu_stop_o), 32'h0);
        checkOutput("mid reset bus_err", 32'(bus_err_o), 32'h0);
        clearInputs();
        @(negedge clk);
        rst = 1'b0;
        dmBus.dm_ack_i   = 1'b1;
        dmBus.dm_rdata_i = 32'hFFFFFFFF;
        @(posedge clk);
        #1 dmBus.dm_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("late ack stop", 32'(lsu_stop_o), 32'h0);
        checkOutput("late ack ldata", MEM_ldata_o, 32'h0);
        applyStimulus(mkVec("LW after reset", F3_W, 1'b0, WD_DRAM, 32'h200, 32'h0, 32'h13579BDF, 0,
                            32'h200, 4'hF, 32'h0, 1, 32'h13579BDF), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
